decode_ctrl_stage: RTL and testbench

//  Buffered, pipelined RV32 decode stage: queues {instr,pc} in a FIFO, decodes the head into a control bundle,

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_decode.sv | 142 ++++++++++++++
 rtl/decode_ctrl_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the decode stage: ALU operation encoding, RV32 opcode
// constants and the control bundle carried from decoder to output slot.
// CTRL_MULDIV_EN (optional) enables the M-extension encodings in ctrl_decode.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_ROR  = 4'b1001,
        ALU_ROL  = 4'b1010,
        ALU_MUL  = 4'b1011,
        ALU_MULH = 4'b1100,
        ALU_DIV  = 4'b1101,
        ALU_REM  = 4'b1110
    } alu_ops_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic memwrite;
        logic memread;
        logic branch;
        logic jump;
        logic alusrc;
    } ctrl_flags_t;

    typedef struct packed {
        ctrl_flags_t flags;
        alu_ops_t    aluop;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        uses_rs1;
        logic        uses_rs2;
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32 decoder: instruction word -> control bundle.
// CTRL_MULDIV_EN: when defined, R-type funct7=0000001 decodes MUL/MULH/DIV/REM;
// otherwise that funct7 is reported illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [6:0]  f7;
    logic [2:0]  f3;
    ctrl_flags_t fl;
    alu_ops_t    op;
    logic        ill;
    logic        u1;
    logic        u2;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Opcode/funct decode; an illegal result squashes every enable to 0.
    always_comb begin
        fl  = '0;
        op  = ALU_ADD;
        ill = 1'b0;
        u1  = 1'b0;
        u2  = 1'b0;
        case (opcode)
            OP_R: begin
                fl.regwrite = 1'b1;
                u1 = 1'b1;
                u2 = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        3'b111:  op = ALU_AND;
                        default: ill = 1'b1;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  op = ALU_SUB;
                        3'b101:  op = ALU_SRA;
                        default: ill = 1'b1;
                    endcase
                end
`ifdef CTRL_MULDIV_EN
                else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000:  op = ALU_MUL;
                        3'b001:  op = ALU_MULH;
                        3'b100:  op = ALU_DIV;
                        3'b110:  op = ALU_REM;
                        default: ill = 1'b1;
                    endcase
                end
`endif
                else begin
                    ill = 1'b1;
                end
            end
            OP_I: begin
                fl.regwrite = 1'b1;
                fl.alusrc   = 1'b1;
                u1 = 1'b1;
                case (f3)
                    3'b000: op = ALU_ADD;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        if (f7 == F7_BASE) op = ALU_SLL;
                        else               ill = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     op = ALU_SRL;
                        else if (f7 == F7_ALT) op = ALU_SRA;
                        else                   ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                fl.memread  = 1'b1;
                fl.memtoreg = 1'b1;
                fl.regwrite = 1'b1;
                fl.alusrc   = 1'b1;
                u1 = 1'b1;
            end
            OP_STORE: begin
                fl.memwrite = 1'b1;
                fl.alusrc   = 1'b1;
                u1 = 1'b1;
                u2 = 1'b1;
            end
            OP_BRANCH: begin
                fl.branch = 1'b1;
                op = ALU_SUB;
                u1 = 1'b1;
                u2 = 1'b1;
            end
            OP_JAL: begin
                fl.regwrite = 1'b1;
                fl.jump     = 1'b1;
            end
            OP_JALR: begin
                fl.regwrite = 1'b1;
                fl.jump     = 1'b1;
                fl.alusrc   = 1'b1;
                u1 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                fl.regwrite = 1'b1;
                fl.alusrc   = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        if (ill) begin
            fl = '0;
            op = ALU_ADD;
            u1 = 1'b0;
            u2 = 1'b0;
        end

        bundle.flags    = fl;
        bundle.aluop    = op;
        bundle.illegal  = ill;
        bundle.rd       = fl.regwrite ? instr[11:7] : 5'd0;
        bundle.rs1      = instr[19:15];
        bundle.rs2      = instr[24:20];
        bundle.uses_rs1 = u1;
        bundle.uses_rs2 = u2;
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Buffered RV32 decode stage: {instr,pc} FIFO, decoder on the FIFO head,
// registered output slot and a one-bubble load-use interlock.
// CTRL_MULDIV_EN (optional, see ctrl_decode) adds MUL/MULH/DIV/REM decode.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. valid and its payload hold until accepted; ready never depends
// combinationally on the same-side valid, and in_ready has no path from out_ready.
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PC_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [PC_W-1:0]               in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_W-1:0]               out_pc,
    output logic [4:0]                    out_rd,
    output logic [4:0]                    out_rs1,
    output logic [4:0]                    out_rs2,
    output logic                          MemtoReg,
    output logic                          RegWrite,
    output logic                          MemWrite,
    output logic                          MemRead,
    output logic                          Branch,
    output logic                          Jump,
    output logic                          ALUSrc,
    output logic [3:0]                    ALUOp,
    output logic                          illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [PC_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ready_flag;

    ctrl_bundle_t    head;
    logic            head_valid;
    logic            push;
    logic            load;
    logic            hazard;

    // Output slot contents (uses_rs* are only needed on the head side).
    logic            slot_valid;
    ctrl_flags_t     slot_flags;
    alu_ops_t        slot_aluop;
    logic            slot_illegal;
    logic [4:0]      slot_rd;
    logic [4:0]      slot_rs1;
    logic [4:0]      slot_rs2;
    logic [PC_W-1:0] slot_pc;

    ctrl_decode u_decode (
        .instr  (instr_mem[rd_ptr]),
        .bundle (head)
    );

    assign head_valid = (count != '0);
    // ready comes only from registered state; flush blocks acceptance that cycle.
    assign in_ready   = ready_flag && (count < DEPTH_C) && !flush;
    assign push       = in_valid && in_ready;

    // Load-use: the head must not enter the slot in the cycle the load leaves it.
    assign hazard = slot_valid && slot_flags.memread && (slot_rd != 5'd0) && head_valid &&
                    ((head.uses_rs1 && (head.rs1 == slot_rd)) ||
                     (head.uses_rs2 && (head.rs2 == slot_rd)));

    assign load = head_valid && (!slot_valid || out_ready) && !hazard && !flush;

    // Ready flag rises on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_flag <= 1'b0;
        else        ready_flag <= 1'b1;
    end

    // FIFO pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: written on accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Output slot: load decoded head, or drop valid when the bundle departs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid   <= 1'b0;
            slot_flags   <= '0;
            slot_aluop   <= ALU_NOP;
            slot_illegal <= 1'b0;
            slot_rd      <= '0;
            slot_rs1     <= '0;
            slot_rs2     <= '0;
            slot_pc      <= '0;
        end else if (flush) begin
            slot_valid   <= 1'b0;
            slot_flags   <= '0;
            slot_aluop   <= ALU_NOP;
            slot_illegal <= 1'b0;
            slot_rd      <= '0;
            slot_rs1     <= '0;
            slot_rs2     <= '0;
            slot_pc      <= '0;
        end else if (load) begin
            slot_valid   <= 1'b1;
            slot_flags   <= head.flags;
            slot_aluop   <= head.aluop;
            slot_illegal <= head.illegal;
            slot_rd      <= head.rd;
            slot_rs1     <= head.rs1;
            slot_rs2     <= head.rs2;
            slot_pc      <= pc_mem[rd_ptr];
        end else if (out_ready) begin
            slot_valid   <= 1'b0;
        end
    end

    assign out_valid  = slot_valid;
    assign out_pc     = slot_pc;
    assign out_rd     = slot_rd;
    assign out_rs1    = slot_rs1;
    assign out_rs2    = slot_rs2;
    assign MemtoReg   = slot_flags.memtoreg;
    assign RegWrite   = slot_flags.regwrite;
    assign MemWrite   = slot_flags.memwrite;
    assign MemRead    = slot_flags.memread;
    assign Branch     = slot_flags.branch;
    assign Jump       = slot_flags.jump;
    assign ALUSrc     = slot_flags.alusrc;
    assign ALUOp      = slot_aluop;
    assign illegal    = slot_illegal;
    assign fill_level = count;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: decode vector table plus directed
// sequences for reset, backpressure, load-use bubble and flush.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        MemtoReg, RegWrite, MemWrite, MemRead, Branch, Jump, ALUSrc;
    logic [3:0]  ALUOp;
    logic        illegal;
    logic [2:0]  fill_level;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] I_ADD = 32'h002081B3;

    decode_ctrl_stage #(.FIFO_DEPTH(4), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .Branch(Branch), .Jump(Jump), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .illegal(illegal), .fill_level(fill_level)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] flags_now();
        return {MemtoReg, RegWrite, MemWrite, MemRead, Branch, Jump, ALUSrc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one instruction from a negedge; returns at the negedge after the accepting edge.
    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        logic done;
        logic hs;
        done = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int c = 0; c < 20 && !done; c++) begin
            hs = in_ready;
            @(negedge clk);
            if (hs) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  flags;
        logic [3:0]  aluop;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // flags order: MemtoReg,RegWrite,MemWrite,MemRead,Branch,Jump,ALUSrc
        vecs[0]  = '{32'h002081B3, 7'b0100000, 4'b0001, 1'b0, 5'd3, 5'd1, 5'd2};  // add
        vecs[1]  = '{32'h402081B3, 7'b0100000, 4'b0010, 1'b0, 5'd3, 5'd1, 5'd2};  // sub
        vecs[2]  = '{32'h0020F1B3, 7'b0100000, 4'b0011, 1'b0, 5'd3, 5'd1, 5'd2};  // and
        vecs[3]  = '{32'h4020D1B3, 7'b0100000, 4'b1000, 1'b0, 5'd3, 5'd1, 5'd2};  // sra
        vecs[4]  = '{32'h0020A1B3, 7'b0000000, 4'b0001, 1'b1, 5'd0, 5'd1, 5'd2};  // slt -> illegal
        vecs[5]  = '{32'hFFF08293, 7'b0100001, 4'b0001, 1'b0, 5'd5, 5'd1, 5'd31}; // addi
        vecs[6]  = '{32'h4030D293, 7'b0100001, 4'b1000, 1'b0, 5'd5, 5'd1, 5'd3};  // srai
        vecs[7]  = '{32'h40309293, 7'b0000000, 4'b0001, 1'b1, 5'd0, 5'd1, 5'd3};  // slli bad f7
        vecs[8]  = '{32'h0000A283, 7'b1101001, 4'b0001, 1'b0, 5'd5, 5'd1, 5'd0};  // lw
        vecs[9]  = '{32'h0020A223, 7'b0010001, 4'b0001, 1'b0, 5'd0, 5'd1, 5'd2};  // sw
        vecs[10] = '{32'h00208063, 7'b0000100, 4'b0010, 1'b0, 5'd0, 5'd1, 5'd2};  // beq
        vecs[11] = '{32'h000000EF, 7'b0100010, 4'b0001, 1'b0, 5'd1, 5'd0, 5'd0};  // jal
        vecs[12] = '{32'h000100E7, 7'b0100011, 4'b0001, 1'b0, 5'd1, 5'd2, 5'd0};  // jalr
        vecs[13] = '{32'h123453B7, 7'b0100001, 4'b0001, 1'b0, 5'd7, 5'd8, 5'd3};  // lui
        vecs[14] = '{32'hFFFFFFFF, 7'b0000000, 4'b0001, 1'b1, 5'd0, 5'd31, 5'd31}; // bad opcode
`ifdef CTRL_MULDIV_EN
        vecs[15] = '{32'h023100B3, 7'b0100000, 4'b1011, 1'b0, 5'd1, 5'd2, 5'd3};  // mul
`else
        vecs[15] = '{32'h023100B3, 7'b0000000, 4'b0001, 1'b1, 5'd0, 5'd2, 5'd3};  // mul -> illegal
`endif

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fill", {29'd0, fill_level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_flags", {25'd0, flags_now()}, 32'd0);
        check("rst_aluop", {28'd0, ALUOp}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        reset = 1'b1;
        #1 check("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

        // ---- add latency: accept edge, then slot edge ----
        out_ready = 1'b1;
        push_one(I_ADD, 32'h100);
        check("add_lat_not_yet", {31'd0, out_valid}, 32'd0);
        check("add_fill_1", {29'd0, fill_level}, 32'd1);
        @(negedge clk);
        check("add_out_valid", {31'd0, out_valid}, 32'd1);
        check("add_regwrite", {31'd0, RegWrite}, 32'd1);
        check("add_aluop", {28'd0, ALUOp}, 32'h1);
        check("add_rd", {27'd0, out_rd}, 32'd3);
        check("add_rs1", {27'd0, out_rs1}, 32'd1);
        check("add_rs2", {27'd0, out_rs2}, 32'd2);
        check("add_pc", out_pc, 32'h100);

        // ---- decode table ----
        for (int i = 0; i < 16; i++) begin
            push_one(vecs[i].instr, 32'h1000 + 32'(i) * 4);
            check($sformatf("v%0d_gap", i), {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_flags", i), {25'd0, flags_now()}, {25'd0, vecs[i].flags});
            check($sformatf("v%0d_aluop", i), {28'd0, ALUOp}, {28'd0, vecs[i].aluop});
            check($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
            check($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_rs1", i), {27'd0, out_rs1}, {27'd0, vecs[i].rs1});
            check($sformatf("v%0d_rs2", i), {27'd0, out_rs2}, {27'd0, vecs[i].rs2});
            check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
        end
        @(negedge clk);

        // ---- backpressure: 6 offered, 5 held (4 FIFO + slot), in-order drain ----
        begin
            int accepted;
            logic hs;
            accepted = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 10; c++) begin
                in_valid = 1'b1;
                in_instr = I_ADD;
                in_pc    = 32'h2000 + 32'(accepted) * 4;
                hs = in_ready;
                @(negedge clk);
                if (hs) begin
                    exp_q.push_back(32'h2000 + 32'(accepted) * 4);
                    accepted++;
                end
            end
            in_valid = 1'b0;
            check("bp_accepted", 32'(accepted), 32'd5);
            check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
            check("bp_fill_full", {29'd0, fill_level}, 32'd4);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            out_ready = 1'b1;
            for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
                if (c == 0) check("bp_full_pop_ready", {31'd0, in_ready}, 32'd0);
                if (c == 1) begin
                    check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
                    check("bp_fill_after_pop", {29'd0, fill_level}, 32'd3);
                end
                if (out_valid) check($sformatf("bp_pc_%0d", c), out_pc, exp_q.pop_front());
                @(negedge clk);
            end
            check("bp_drained", 32'(exp_q.size()), 32'd0);
            check("bp_idle", {31'd0, out_valid}, 32'd0);
        end

        // ---- load-use: lw x5 then add x6,x5,x5 -> one bubble ----
        out_ready = 1'b1;
        push_one(32'h0000A283, 32'h300);
        push_one(32'h00528333, 32'h304);
        check("lu_lw_valid", {31'd0, out_valid}, 32'd1);
        check("lu_lw_memread", {31'd0, MemRead}, 32'd1);
        check("lu_lw_pc", out_pc, 32'h300);
        @(negedge clk);
        check("lu_bubble", {31'd0, out_valid}, 32'd0);
        check("lu_bubble_fill", {29'd0, fill_level}, 32'd1);
        @(negedge clk);
        check("lu_add_valid", {31'd0, out_valid}, 32'd1);
        check("lu_add_pc", out_pc, 32'h304);
        check("lu_add_rd", {27'd0, out_rd}, 32'd6);
        check("lu_add_memread", {31'd0, MemRead}, 32'd0);
        @(negedge clk);

        // ---- load to x0 never stalls ----
        push_one(32'h0000A003, 32'h400);
        push_one(32'h00000333, 32'h404);
        check("x0_lw_pc", out_pc, 32'h400);
        @(negedge clk);
        check("x0_no_bubble", {31'd0, out_valid}, 32'd1);
        check("x0_add_pc", out_pc, 32'h404);
        @(negedge clk);

        // ---- flush with 3 queued ----
        out_ready = 1'b0;
        push_one(I_ADD, 32'h500);
        push_one(I_ADD, 32'h504);
        push_one(I_ADD, 32'h508);
        check("fl_pre_fill", {29'd0, fill_level}, 32'd2);
        flush = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'hDEAD;
        #1 check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_fill", {29'd0, fill_level}, 32'd0);
        out_ready = 1'b1;
        push_one(I_ADD, 32'h600);
        @(negedge clk);
        check("fl_next_valid", {31'd0, out_valid}, 32'd1);
        check("fl_next_pc", out_pc, 32'h600);
        check("fl_next_rd", {27'd0, out_rd}, 32'd3);
        @(negedge clk);

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b0;
        push_one(32'h0000A283, 32'h700);
        push_one(I_ADD, 32'h704);
        push_one(I_ADD, 32'h708);
        #2 reset = 1'b0;
        #1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_fill", {29'd0, fill_level}, 32'd0);
        check("mr_flags", {25'd0, flags_now()}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mr_ready_held", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("mr_ready_rise", {31'd0, in_ready}, 32'd1);
        check("mr_still_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        push_one(I_ADD, 32'h800);
        @(negedge clk);
        check("mr_recover_valid", {31'd0, out_valid}, 32'd1);
        check("mr_recover_pc", out_pc, 32'h800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
